// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - wave codes, sweep FSM encoding and waveform sequencing helper
package dds_pkg;

    localparam logic [1:0] WAVE_SIN = 2'b11;
    localparam logic [1:0] WAVE_SQU = 2'b10;
    localparam logic [1:0] WAVE_TRI = 2'b01;
    localparam logic [1:0] WAVE_SAW = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SWEEP_UP = 2'd1,
        ST_SWEEP_DN = 2'd2
    } sweep_state_e;

    function automatic logic [1:0] next_wave(input logic [1:0] wave);
        logic [1:0] nxt;
        case (wave)
            WAVE_SIN: nxt = WAVE_SQU;
            WAVE_SQU: nxt = WAVE_TRI;
            WAVE_TRI: nxt = WAVE_SAW;
            default:  nxt = WAVE_SIN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dds_sweep_tick.sv
// rtl/dds_sweep_tick.sv - counts frame_start pulses and ticks once every SWEEP_FRAMES frames
module dds_sweep_tick
    import dds_pkg::*;
#(
    parameter logic [7:0] SWEEP_FRAMES = 8'd30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    logic [7:0] cnt_q, cnt_d;
    logic       wrap;

    assign wrap = enable && frame_start && (cnt_q == SWEEP_FRAMES - 8'd1);
    assign tick = wrap && !clear;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (enable && frame_start) begin
            cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_cfg_ctrl.sv
// rtl/dds_cfg_ctrl.sv - stages key/sweep changes to wave and frequency, commits them on frame start
module dds_cfg_ctrl
    import dds_pkg::*;
#(
    parameter logic [31:0] FREQ_STEP    = 32'd1,
    parameter logic [7:0]  FREQ_MAX_IDX = 8'd100,
    parameter logic [7:0]  SWEEP_FRAMES = 8'd30
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_wave,
    input  logic        key_up,
    input  logic        key_dn,
    input  logic        key_sweep,
    input  logic        frame_start,
    output logic [1:0]  wave_select,
    output logic [31:0] freq_ctrl,
    output logic        cfg_update,
    output logic        sweep_active
);

    sweep_state_e state_q, state_d;
    logic [1:0]   pend_wave_q, pend_wave_d;
    logic [7:0]   pend_idx_q, pend_idx_d;
    logic [1:0]   wave_q;
    logic [7:0]   cur_idx_q;
    logic [31:0]  freq_q;
    logic         upd_q;
    logic         tick;
    logic         commit;

    // Counter is held clear in IDLE and on every toggle, so a stop/start restarts the frame count.
    dds_sweep_tick #(
        .SWEEP_FRAMES(SWEEP_FRAMES)
    ) u_tick (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .frame_start(frame_start),
        .enable     (state_q != ST_IDLE),
        .clear      ((state_q == ST_IDLE) || key_sweep),
        .tick       (tick)
    );

    always_comb begin
        state_d     = state_q;
        pend_wave_d = pend_wave_q;
        pend_idx_d  = pend_idx_q;

        if (key_wave) begin
            pend_wave_d = next_wave(pend_wave_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (key_sweep) begin
                    state_d = ST_SWEEP_UP;
                end
                if (key_up && !key_dn && pend_idx_q != FREQ_MAX_IDX) begin
                    pend_idx_d = pend_idx_q + 8'd1;
                end else if (key_dn && !key_up && pend_idx_q != 8'd1) begin
                    pend_idx_d = pend_idx_q - 8'd1;
                end
            end
            ST_SWEEP_UP: begin
                if (key_sweep) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (pend_idx_q == FREQ_MAX_IDX) begin
                        state_d    = ST_SWEEP_DN;
                        pend_idx_d = pend_idx_q - 8'd1;
                    end else begin
                        pend_idx_d = pend_idx_q + 8'd1;
                    end
                end
            end
            ST_SWEEP_DN: begin
                if (key_sweep) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (pend_idx_q == 8'd1) begin
                        state_d    = ST_SWEEP_UP;
                        pend_idx_d = pend_idx_q + 8'd1;
                    end else begin
                        pend_idx_d = pend_idx_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Commit compares registered staging only, so a same-cycle key waits for the next frame.
    assign commit = frame_start && ((pend_wave_q != wave_q) || (pend_idx_q != cur_idx_q));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            pend_wave_q <= WAVE_SIN;
            pend_idx_q  <= 8'd1;
            wave_q      <= WAVE_SIN;
            cur_idx_q   <= 8'd1;
            freq_q      <= FREQ_STEP;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_wave_q <= pend_wave_d;
            pend_idx_q  <= pend_idx_d;
            upd_q       <= commit;
            if (commit) begin
                wave_q    <= pend_wave_q;
                cur_idx_q <= pend_idx_q;
                freq_q    <= FREQ_STEP * 32'(pend_idx_q);
            end
        end
    end

    assign wave_select  = wave_q;
    assign freq_ctrl    = freq_q;
    assign cfg_update   = upd_q;
    assign sweep_active = (state_q != ST_IDLE);

endmodule
